// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared constants for the single-cycle RISC-V core. The adder,
//             next-PC mux, instruction memory and program counter all size
//             themselves from these values so the core agrees on one address
//             width and one reset vector.
//  Contents : XLEN         - architectural register/address width
//             RESET_VECTOR - address the core fetches from out of reset
//             addr_t       - XLEN-wide address type
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module   : program_counter
//  Purpose  : Architectural PC register. Loads pc_next on every rising clock
//             edge (no enable, no stall) and returns to RESET_VECTOR the
//             instant reset rises, independent of the clock.
//  Ports    : clk     - in , 1     : rising-edge clock
//             reset   - in , 1     : asynchronous active-high reset
//             pc_next - in , WIDTH : next PC from the next-PC mux, taken verbatim
//             address - out, WIDTH : current PC, drives instruction memory
//  Revision : 1.0 - initial release
// ============================================================================
module program_counter #(
  parameter int unsigned      WIDTH        = riscv_pkg::XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(riscv_pkg::RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] address
);

  logic [WIDTH-1:0] r_address;

  // pc_next is loaded exactly as presented: no alignment masking, no
  // increment and no wrap handling, so 0xFFFF_FFFC -> 0 is just a load of 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_address <= RESET_VECTOR;
    end else begin
      r_address <= pc_next;
    end
  end

  // Register output only; nothing combinational from pc_next reaches address.
  assign address = r_address;

  // Misaligned fetch targets point at a bug upstream in the next-PC logic.
  // This only warns; the value is still loaded unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (pc_next[1:0] == 2'b00)
        else $warning("program_counter: misaligned pc_next 0x%h", pc_next);
    end
  end

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_counter
//  Purpose  : Self-checking bench for program_counter. Two instances share
//             stimulus: one with the default reset vector and one with
//             0x8000_0000. A directed phase follows the documented timeline,
//             then a randomized phase mixes loads with asynchronous resets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_counter;

  localparam logic [31:0] c_RV0 = 32'h0000_0000;
  localparam logic [31:0] c_RV1 = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next;
  logic [31:0] address0;
  logic [31:0] address1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what each PC must hold, from the behavioural rules.
  logic [31:0] exp0;
  logic [31:0] exp1;
  bit          exp_valid = 1'b0;

  program_counter #(
    .WIDTH       (32),
    .RESET_VECTOR(c_RV0)
  ) dut0 (
    .clk    (clk),
    .reset  (reset),
    .pc_next(pc_next),
    .address(address0)
  );

  program_counter #(
    .WIDTH       (32),
    .RESET_VECTOR(c_RV1)
  ) dut1 (
    .clk    (clk),
    .reset  (reset),
    .pc_next(pc_next),
    .address(address1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Edge rule: an edge with reset high keeps the reset vector, otherwise the
  // PC becomes whatever pc_next was at that edge.
  always @(posedge clk) begin
    if (reset) begin
      exp0 = c_RV0;
      exp1 = c_RV1;
      exp_valid = 1'b1;
    end else if (exp_valid) begin
      exp0 = pc_next;
      exp1 = pc_next;
    end
  end

  // Reset rising takes effect immediately, no clock needed.
  always @(posedge reset) begin
    exp0 = c_RV0;
    exp1 = c_RV1;
    exp_valid = 1'b1;
  end

  // Per-cycle compare, 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_valid) begin
      check("model_rv0", address0, exp0);
      check("model_rv1", address1, exp1);
    end
  end

  logic [31:0] rnd;

  initial begin
    reset   = 1'b1;
    pc_next = 32'h0;

    // Power-up reset held across the 5 ns edge.
    #7;   // t=7
    check("por_rv0", address0, 32'h0000_0000);
    check("por_rv1", address1, 32'h8000_0000);

    // Sequential loads: release at 10 ns.
    #3;   // t=10
    reset   = 1'b0;
    pc_next = 32'h4;
    #7;   // t=17
    check("load_4", address0, 32'h4);
    #3;   // t=20
    pc_next = 32'h8;
    #7;   // t=27
    check("load_8", address0, 32'h8);
    #3;   // t=30
    pc_next = 32'hC;
    #7;   // t=37
    check("load_c", address0, 32'hC);
    check("load_c_rv1", address1, 32'hC);

    // Asynchronous reset between edges.
    #3;   // t=40
    reset = 1'b1;
    #1;   // t=41
    check("async_rst_rv0", address0, 32'h0);
    check("async_rst_rv1", address1, 32'h8000_0000);
    #6;   // t=47, edge at 45 with pc_next=0xC must not load
    check("rst_hold_rv0", address0, 32'h0);
    check("rst_hold_rv1", address1, 32'h8000_0000);

    // Recovery.
    #3;   // t=50
    reset   = 1'b0;
    pc_next = 32'h10;
    #7;   // t=57
    check("recover_10", address0, 32'h10);

    // Wrap and misalignment (warning expected for 0x6).
    #3;   // t=60
    pc_next = 32'hFFFF_FFFC;
    #7;
    check("wrap_top", address0, 32'hFFFF_FFFC);
    #3;
    pc_next = 32'h0;
    #7;
    check("wrap_zero", address0, 32'h0);
    #3;
    pc_next = 32'h6;
    #7;
    check("misaligned_6", address0, 32'h6);
    check("misaligned_6_rv1", address1, 32'h6);
    #3;   // back on a falling edge

    // Randomized phase: drive on falling edges, assert reset at random
    // offsets strictly between edges.
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      if ($urandom_range(0, 15) != 0) rnd = rnd & 32'hFFFF_FFFC;
      pc_next = rnd;
      if (!reset && $urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        check("rand_async_rv0", address0, c_RV0);
        check("rand_async_rv1", address1, c_RV1);
        @(negedge clk);
      end else begin
        if (reset && $urandom_range(0, 1) == 0) reset = 1'b0;
        @(negedge clk);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_program_counter
`default_nettype wire
